// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer with demand-served side phase,
// per-phase countdown seconds and a free-running display page select.
module traffic_phase_sequencer #(
  parameter int ClockPeriod_ns = 20,
  parameter int Tick_ns        = 1_000_000_000,
  parameter int TSize          = 4,
  parameter int PSize          = 4,
  parameter int GreenMain      = 9,
  parameter int GreenSide      = 7,
  parameter int YellowTime     = 3,
  parameter int ClearTime      = 2,
  parameter int PageTime       = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             SideCar,
  input  logic             PedButton,
  output logic [2:0]       MainLamp,
  output logic [2:0]       SideLamp,
  output logic             PedMainWalk,
  output logic             PedSideWalk,
  output logic [TSize-1:0] TLsec,
  output logic [TSize-1:0] TMsec,
  output logic [TSize-1:0] TRsec,
  output logic [PSize-1:0] PLsec,
  output logic [PSize-1:0] PRsec,
  output logic             TPswitch
);

  localparam int TickDiv = Tick_ns / ClockPeriod_ns;
  localparam int PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int PageW   = (PageTime > 1) ? $clog2(PageTime) : 1;
  localparam int TMax    = (1 << TSize) - 1;
  localparam int PMax    = (1 << PSize) - 1;

  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  if (TickDiv < 1) begin : g_bad_tick
    $error("Tick_ns must be at least one clock period");
  end
  if (GreenMain < 1 || GreenMain > TMax || GreenSide < 1 || GreenSide > TMax ||
      YellowTime < 1 || YellowTime > TMax || ClearTime < 1 || ClearTime > TMax ||
      PageTime < 1 || PageTime > TMax) begin : g_bad_duration
    $error("duration parameter out of range 1..2^TSize-1");
  end
  if (GreenMain > PMax || GreenSide > PMax) begin : g_bad_walk
    $error("green duration does not fit the pedestrian seconds width");
  end

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLEAR1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLEAR2 = 3'd5
  } state_t;

  function automatic logic [TSize-1:0] duration(input state_t st);
    logic [TSize-1:0] d;
    case (st)
      MAIN_G:  d = TSize'(GreenMain);
      MAIN_Y:  d = TSize'(YellowTime);
      SIDE_G:  d = TSize'(GreenSide);
      SIDE_Y:  d = TSize'(YellowTime);
      default: d = TSize'(ClearTime);
    endcase
    return d;
  endfunction

  function automatic logic [2:0] main_lamp(input state_t st);
    logic [2:0] l;
    case (st)
      MAIN_G:  l = LampG;
      MAIN_Y:  l = LampY;
      default: l = LampR;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] side_lamp(input state_t st);
    logic [2:0] l;
    case (st)
      SIDE_G:  l = LampG;
      SIDE_Y:  l = LampY;
      default: l = LampR;
    endcase
    return l;
  endfunction

  state_t           state_r, state_next_s;
  logic [TSize-1:0] sec_cnt_r, sec_next_s;
  logic [PreW-1:0]  pre_cnt_r, pre_next_s;
  logic [PageW-1:0] page_cnt_r, page_next_s;
  logic             tp_r, tp_next_s;
  logic             pending_r, pending_next_s;
  logic             car_meta_r, car_sync_r, ped_meta_r, ped_sync_r;
  logic             tick_s, req_s;

  logic [2:0]       main_lamp_r, side_lamp_r;
  logic             ped_main_walk_r, ped_side_walk_r;
  logic [TSize-1:0] tl_r, tm_r, tr_r;
  logic [PSize-1:0] pl_r, pr_r;
  logic [TSize-1:0] tl_next_s, tm_next_s, tr_next_s;
  logic [PSize-1:0] pl_next_s, pr_next_s;

  assign tick_s = (pre_cnt_r == PreW'(TickDiv - 1));
  assign req_s  = car_sync_r | ped_sync_r;

  // Prescaler, page counter and display page toggle; all free-running.
  always_comb begin
    pre_next_s  = pre_cnt_r;
    page_next_s = page_cnt_r;
    tp_next_s   = tp_r;
    if (tick_s) begin
      pre_next_s = {PreW{1'b0}};
      if (page_cnt_r == PageW'(PageTime - 1)) begin
        page_next_s = {PageW{1'b0}};
        tp_next_s   = ~tp_r;
      end else begin
        page_next_s = page_cnt_r + PageW'(1);
      end
    end else begin
      pre_next_s = pre_cnt_r + PreW'(1);
    end
  end

  // Phase sequencing, seconds countdown and side-demand latch.
  always_comb begin
    state_next_s   = state_r;
    sec_next_s     = sec_cnt_r;
    pending_next_s = pending_r;
    if (tick_s && (sec_cnt_r == TSize'(1))) begin
      case (state_r)
        MAIN_G:  state_next_s = pending_r ? MAIN_Y : MAIN_G;
        MAIN_Y:  state_next_s = CLEAR1;
        CLEAR1:  state_next_s = SIDE_G;
        SIDE_G:  state_next_s = SIDE_Y;
        SIDE_Y:  state_next_s = CLEAR2;
        CLEAR2:  state_next_s = MAIN_G;
        default: state_next_s = CLEAR2;
      endcase
      sec_next_s = duration(state_next_s);
    end else if (tick_s) begin
      sec_next_s = sec_cnt_r - TSize'(1);
    end else begin
      sec_next_s = sec_cnt_r;
    end
    // Entering SIDE_G serves the demand, so clear beats a coincident set.
    if ((state_next_s == SIDE_G) && (state_r != SIDE_G)) begin
      pending_next_s = 1'b0;
    end else if (req_s && (state_r != SIDE_G)) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Output decode from the next state so registered outputs track the phase edge.
  always_comb begin
    tl_next_s = {TSize{1'b0}};
    tm_next_s = {TSize{1'b0}};
    tr_next_s = {TSize{1'b0}};
    pl_next_s = {PSize{1'b0}};
    pr_next_s = {PSize{1'b0}};
    case (state_next_s)
      MAIN_G: begin
        tl_next_s = sec_next_s;
        pr_next_s = PSize'(sec_next_s);
      end
      MAIN_Y:  tl_next_s = sec_next_s;
      SIDE_G: begin
        tm_next_s = sec_next_s;
        pl_next_s = PSize'(sec_next_s);
      end
      SIDE_Y:  tm_next_s = sec_next_s;
      default: tr_next_s = sec_next_s;
    endcase
  end

  // Input synchronisers, state registers and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      car_meta_r      <= 1'b0;
      car_sync_r      <= 1'b0;
      ped_meta_r      <= 1'b0;
      ped_sync_r      <= 1'b0;
      state_r         <= CLEAR2;
      sec_cnt_r       <= TSize'(ClearTime);
      pre_cnt_r       <= {PreW{1'b0}};
      page_cnt_r      <= {PageW{1'b0}};
      tp_r            <= 1'b0;
      pending_r       <= 1'b0;
      main_lamp_r     <= LampR;
      side_lamp_r     <= LampR;
      ped_main_walk_r <= 1'b0;
      ped_side_walk_r <= 1'b0;
      tl_r            <= {TSize{1'b0}};
      tm_r            <= {TSize{1'b0}};
      tr_r            <= TSize'(ClearTime);
      pl_r            <= {PSize{1'b0}};
      pr_r            <= {PSize{1'b0}};
    end else begin
      car_meta_r      <= SideCar;
      car_sync_r      <= car_meta_r;
      ped_meta_r      <= PedButton;
      ped_sync_r      <= ped_meta_r;
      state_r         <= state_next_s;
      sec_cnt_r       <= sec_next_s;
      pre_cnt_r       <= pre_next_s;
      page_cnt_r      <= page_next_s;
      tp_r            <= tp_next_s;
      pending_r       <= pending_next_s;
      main_lamp_r     <= main_lamp(state_next_s);
      side_lamp_r     <= side_lamp(state_next_s);
      ped_main_walk_r <= (state_next_s == SIDE_G);
      ped_side_walk_r <= (state_next_s == MAIN_G);
      tl_r            <= tl_next_s;
      tm_r            <= tm_next_s;
      tr_r            <= tr_next_s;
      pl_r            <= pl_next_s;
      pr_r            <= pr_next_s;
    end
  end

  assign MainLamp    = main_lamp_r;
  assign SideLamp    = side_lamp_r;
  assign PedMainWalk = ped_main_walk_r;
  assign PedSideWalk = ped_side_walk_r;
  assign TLsec       = tl_r;
  assign TMsec       = tm_r;
  assign TRsec       = tr_r;
  assign PLsec       = pl_r;
  assign PRsec       = pr_r;
  assign TPswitch    = tp_r;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Cycle-level controller for a two-road intersection: main road, side road, and a pedestrian crossing on each road.
- Sequences the lamp phases and produces per-phase countdown seconds (TLsec, TMsec, TRsec, PLsec, PRsec) plus the TPswitch page select.
- These outputs feed the eight-digit seven-segment seconds display driver directly.
- Side phase is served only on demand: side-road car sensor or pedestrian button.

Parameters:
- ClockPeriod_ns, 20: clock period.
- Tick_ns, 1_000_000_000: countdown tick period. TickDiv = Tick_ns/ClockPeriod_ns cycles.
- TSize, 4: width of traffic seconds outputs.
- PSize, 4: width of pedestrian seconds outputs.
- GreenMain, 9: main green seconds.
- GreenSide, 7: side green seconds.
- YellowTime, 3: yellow seconds, both roads.
- ClearTime, 2: all-red clearance seconds.
- PageTime, 2: seconds per display page before TPswitch toggles.

Ports:
- Clock  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- SideCar  in  1  side-road vehicle sensor, asynchronous level
- PedButton  in  1  pedestrian push-button, asynchronous level
- MainLamp  out  3  {R,Y,G}, one-hot
- SideLamp  out  3  {R,Y,G}, one-hot
- PedMainWalk  out  1  walk signal for crossing the main road
- PedSideWalk  out  1  walk signal for crossing the side road
- TLsec  out  TSize  main-road seconds remaining
- TMsec  out  TSize  side-road seconds remaining
- TRsec  out  TSize  clearance seconds remaining
- PLsec  out  PSize  main-crossing walk seconds remaining
- PRsec  out  PSize  side-crossing walk seconds remaining
- TPswitch  out  1  display page: 0 = traffic, 1 = pedestrian

Behaviour:
- Reset: one clock; Reset_n is asynchronous and active-low.
  - While Reset_n = 0: State = CLEAR2, SecCnt = ClearTime, prescaler = 0, page counter = 0, TPswitch = 0, Pending = 0, synchronisers = 0.
  - Resulting outputs: MainLamp = SideLamp = 3'b100, both walks 0, TRsec = ClearTime, all other seconds outputs 0.
  - Reset asserted mid-phase aborts immediately to this state.
- Inputs: SideCar and PedButton each pass through a 2-flop synchroniser (2-cycle latency).
- Tick: prescaler counts 0..TickDiv-1 and wraps. Tick is a 1-cycle pulse at wrap; it is free-running and independent of state.
- States and lamps:
  - MAIN_G: main G, side R, PedSideWalk = 1.
  - MAIN_Y: main Y, side R.
  - CLEAR1: all R.
  - SIDE_G: side G, main R, PedMainWalk = 1.
  - SIDE_Y: side Y, main R.
  - CLEAR2: all R.
  - Walk outputs are 0 in every other state.
- SecCnt:
  - Loaded with the state duration on state entry.
  - Decremented on each Tick.
  - On a Tick with SecCnt == 1, the next state is entered and its duration loaded in the same edge.
  - Displayed values therefore run Duration..1; 0 is never displayed from an active counter.
- Transitions:
  - MAIN_G → MAIN_Y if Pending = 1.
  - MAIN_G → MAIN_G if Pending = 0, reloading GreenMain; the green is extended in whole GreenMain blocks.
  - MAIN_Y → CLEAR1 → SIDE_G → SIDE_Y → CLEAR2 → MAIN_G, unconditional.
- Pending:
  - Set on any cycle where synchronised SideCar or PedButton is 1 and State ≠ SIDE_G.
  - Cleared on the edge that enters SIDE_G; clear wins over a simultaneous set.
  - Requests during SIDE_G are dropped, since that demand is being served.
- Seconds outputs: decoded from State and SecCnt only, so they update on the same edge as the state.
  - TLsec = SecCnt in MAIN_G/MAIN_Y, else 0.
  - TMsec = SecCnt in SIDE_G/SIDE_Y, else 0.
  - TRsec = SecCnt in CLEAR1/CLEAR2, else 0.
  - PRsec = SecCnt in MAIN_G, else 0.
  - PLsec = SecCnt in SIDE_G, else 0.
- TPswitch: page counter counts Ticks 0..PageTime-1. On the Tick that wraps it, TPswitch toggles. It is independent of state.
- Width rules: all duration parameters are in 1..2^TSize-1, and GreenMain, GreenSide ≤ 2^PSize-1. Any violation is an elaboration-time error. Lamps are never all-off and never show two colours.

Test Plan (ClockPeriod_ns = 20, Tick_ns = 80 → TickDiv = 4, PageTime = 2; all other parameters at default):
1. Release reset, no requests → CLEAR2 for 2 Ticks (TRsec 2,1), then MAIN_G with TLsec = PRsec = 9..1, repeating; SideLamp stays 100 and the side phase is never entered.
2. Pulse PedButton for 1 cycle mid-MAIN_G → green runs to TLsec = 1, then MAIN_Y 3..1, CLEAR1 2..1, SIDE_G with TMsec = PLsec = 7..1 and PedMainWalk = 1, SIDE_Y 3..1, CLEAR2, MAIN_G; Pending = 0 after SIDE_G entry.
3. Hold SideCar high continuously → back-to-back full cycles; no request is lost or double-served, and the first MAIN_G after each CLEAR2 lasts exactly 9 Ticks.
4. Assert SideCar on the same cycle Pending clears at SIDE_G entry → Pending = 0 afterwards; next MAIN_G extends unless a new request arrives.
5. Assert Reset_n = 0 during SIDE_G with TMsec = 4 → all outputs take reset values immediately without waiting for a clock edge; after release, sequence matches scenario 1.
6. Observe TPswitch over 8 Ticks from reset → toggles every 2 Ticks (0,0,1,1,0,0,1,1), unaffected by state changes.
